// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: state encoding, buffer entry layout and PC helpers.
// Pure declarations; no latency or flow-control behaviour of its own.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int IMM_W   = 16;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries with flush; head is visible the cycle after push.
// Push is dropped when full unless a pop frees the slot in the same cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_push_vld,
  input  fetch_entry_t  i_push_dat,
  input  logic          i_pop_rdy,
  output fetch_entry_t  o_head_dat,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  assign w_pop  = i_pop_rdy && !o_empty;
  assign w_push = i_push_vld && (!o_full || w_pop);

  // Flush only rewinds the pointers; stale storage is never visible while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues word-aligned imem requests, buffers responses, feeds decode; 1 cycle rsp->instr_valid.
// Requests are credit-limited to free buffer slots; redirects flush and drain in-flight responses. Option: FETCH_PERF_CNT_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [XLEN-1:0]    instr_pc,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0] r_outstanding;

  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic [CW-1:0]   w_outstanding_nxt;
  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_pop;
  logic [CW:0]     w_credit_sum;
  logic            w_credit;

  fetch_entry_t  w_buf_head;
  fetch_entry_t  w_buf_push;
  logic [CW-1:0] w_buf_count;
  logic          w_buf_full;
  logic          w_buf_empty;

  fetch_entry_t  w_pcq_head;
  fetch_entry_t  w_pcq_push;
  logic [CW-1:0] w_pcq_count;
  logic          w_pcq_full;
  logic          w_pcq_empty;

  assign instr_valid   = !w_buf_empty && !reset;
  assign instr_data    = w_buf_head.data;
  assign instr_pc      = w_buf_head.pc;
  assign w_pop         = instr_valid && instr_ready;
  assign imem_req_addr = r_fetch_pc;
  assign w_req_fire    = imem_req_valid && imem_req_ready;
  assign w_rsp_keep    = imem_rsp_valid && (r_state == FETCH) && !redirect_valid && !w_pcq_empty;

  // In FETCH the PC queue depth equals the outstanding count. A slot being
  // popped this cycle counts as free, which sustains 1 instr/cycle.
  assign w_credit_sum = (CW+1)'(w_pcq_count) + (CW+1)'(w_buf_count) - (CW+1)'(w_pop);
  assign w_credit     = (w_credit_sum < (CW+1)'(BUF_DEPTH)) && !w_pcq_full && !(w_buf_full && !w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FETCH;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    imem_req_valid    = 1'b0;
    w_outstanding_nxt = r_outstanding;

    if ((r_state == FETCH) && !redirect_valid && !reset) begin
      imem_req_valid = w_credit;
    end

    w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);

    if (redirect_valid) begin
      w_fetch_pc_nxt = align_pc(redirect_pc);
    end else if (w_req_fire) begin
      w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
    end

    unique case (r_state)
      FETCH: begin
        if (redirect_valid && (w_outstanding_nxt != '0)) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (w_outstanding_nxt == '0) begin
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_comb begin
    w_buf_push      = w_pcq_head;
    w_buf_push.data = imem_rsp_data;
    w_pcq_push      = '0;
    w_pcq_push.pc   = r_fetch_pc;
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_instr_buf (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (redirect_valid),
    .i_push_vld (w_rsp_keep),
    .i_push_dat (w_buf_push),
    .i_pop_rdy  (w_pop),
    .o_head_dat (w_buf_head),
    .o_count    (w_buf_count),
    .o_full     (w_buf_full),
    .o_empty    (w_buf_empty)
  );

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_pc_queue (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (redirect_valid),
    .i_push_vld (w_req_fire),
    .i_push_dat (w_pcq_push),
    .i_pop_rdy  (w_rsp_keep),
    .o_head_dat (w_pcq_head),
    .o_count    (w_pcq_count),
    .o_full     (w_pcq_full),
    .o_empty    (w_pcq_empty)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetch_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (redirect_valid) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage upstream of the immediate sign-extender and the decode logic.
- Generates word-aligned PCs and issues requests to instruction memory over a valid/ready request channel, then receives in-order responses.
- Buffers returned instructions in a small FIFO and presents them, with their PC, to decode over a valid/ready handshake.
- Decode forwards instr_data[15:0] to the sign-extender. Supports redirects (branch/jump) with flush of in-flight and buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits[1:0] must be 0.
- BUF_DEPTH, 2: instruction buffer entries; power of two, at least 2; also the maximum number of in-flight requests.

Ports:
- clk, input, 1: clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- imem_req_valid, output, 1: request valid.
- imem_req_ready, input, 1: memory accepts request.
- imem_req_addr, output, 32: word-aligned fetch address.
- imem_rsp_valid, input, 1: response valid; in order; at least 1 cycle after acceptance; no backpressure.
- imem_rsp_data, input, 32: fetched instruction.
- redirect_valid, input, 1: one-cycle redirect pulse.
- redirect_pc, input, 32: new fetch PC; bits[1:0] are ignored and forced to 0.
- instr_valid, output, 1: instruction available to decode.
- instr_ready, input, 1: decode accepts.
- instr_data, output, 32: instruction; [15:0] is the immediate field.
- instr_pc, output, 32: PC of instr_data.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values:
  - state = FETCH, fetch_pc = RESET_PC, outstanding = 0, buffer empty.
  - imem_req_valid = 0 during the reset cycle; instr_valid = 0.
  - instr_data = 0, instr_pc = 0, imem_req_addr = RESET_PC.
- Credit rule: imem_req_valid = (state == FETCH) && (outstanding + occupancy < BUF_DEPTH). A response therefore always finds a free buffer slot.
- Request acceptance (valid && ready): fetch_pc += 4, wrapping modulo 2^32. The issued PC is pushed onto an internal PC queue of BUF_DEPTH entries; outstanding++.
- imem_req_addr equals fetch_pc and must hold stable while valid && !ready.
- Response in FETCH: {data, popped PC} is pushed into the buffer; outstanding--.
- Accepted request and response in the same cycle: outstanding is unchanged.
- Output: instr_valid = !empty. instr_data/instr_pc show the head entry; pop on instr_valid && instr_ready.
- Minimum latency is 1 cycle from response to instr_valid. Back-to-back throughput is 1 instruction/cycle when memory latency is at most BUF_DEPTH-1.
- Buffer full with instr_ready = 0: no new requests issue and the head holds stable.
- FSM states: FETCH, FLUSH.
- FETCH + redirect_valid:
  - Buffer and PC queue are cleared and fetch_pc = redirect_pc & ~3.
  - Any response arriving that cycle is discarded.
  - No request is issued in the redirect cycle.
  - Next state is FLUSH if the outstanding count after this cycle is greater than 0, else FETCH.
- Redirect with a same-cycle instr handshake: the handshake completes (decode consumed it), then the flush applies.
- FLUSH:
  - No requests; instr_valid = 0.
  - Each response is discarded with outstanding--.
  - When outstanding reaches 0 → FETCH, with the first request the following cycle.
- Redirect during FLUSH: fetch_pc is updated to the newest target; the state stays FLUSH.
- reset asserted mid-operation: immediate return to reset values. Responses to pre-reset requests are the memory's responsibility and must not be sent after reset.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs perf_fetch_cnt (increments on each instr handshake) and perf_flush_cnt (increments on each redirect).
  - Both counters clear on reset and wrap at 2^32.
- Undefined: both ports still exist and are tied to 0; no counter flops are present.

Decomposition:
- Shared package fetch_pkg:
  - XLEN = 32, INSTR_W = 32, IMM_W = 16, PC_STEP = 4.
  - fetch_state_t enum {FETCH, FLUSH}.
  - fetch_entry_t struct {data, pc}.
- Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t with flush input, count output, and full/empty flags. It is instantiated for both the instruction buffer and the PC queue.

Test Plan:
- Reset release, memory ready, 1-cycle latency, instr_ready = 1 → requests at 0x0, 0x4, 0x8; instr_pc 0x0, 0x4, 0x8 on consecutive cycles after the first.
- instr_ready = 0 for 10 cycles → at most BUF_DEPTH requests are issued; imem_req_valid = 0 while full; the head stays at pc 0x0.
- 2 requests outstanding, redirect_pc = 0x1003 → enters FLUSH; both responses are dropped; next request address is 0x1000; instr_pc = 0x1000.
- Redirect to 0x2000 in FLUSH, then redirect to 0x3000 in FLUSH → the first fetch after FLUSH is 0x3000.
- fetch_pc = 0xFFFF_FFFC accepted → the next request address is 0x0000_0000.
- reset asserted with the buffer full → the next cycle has instr_valid = 0, outstanding = 0, and imem_req_addr = RESET_PC.
